// File: rtl/turn_controller.sv
// Tic-tac-toe turn sequencer: drives board-storage writes, alternates players, detects win/draw.
// Optional STARTER_ALT_EN: alternate the starting player on every new_game restart.
module turn_controller #(
    parameter logic [1:0] P1_CODE = 2'd1,
    parameter logic [1:0] P2_CODE = 2'd2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [3:0] sel,
    input  logic       new_game,
    input  logic       valid,
    input  logic [1:0] grid_A1,
    input  logic [1:0] grid_A2,
    input  logic [1:0] grid_A3,
    input  logic [1:0] grid_B1,
    input  logic [1:0] grid_B2,
    input  logic [1:0] grid_B3,
    input  logic [1:0] grid_C1,
    input  logic [1:0] grid_C2,
    input  logic [1:0] grid_C3,
    output logic       clear,
    output logic [1:0] user,
    output logic [3:0] move,
    output logic       turn,
    output logic       illegal,
    output logic [1:0] winner,
    output logic       game_over,
    output logic [3:0] move_count,
    output logic       busy
);

    // state  | meaning
    // CLEAR  | emit one clear strobe, reset game bookkeeping
    // READY  | wait for a player request
    // ISSUE  | present move/user to board storage for one cycle
    // RESULT | sample board write result
    // CHECK  | look for a completed line or a full board
    // OVER   | game finished, hold result until new_game
    typedef enum logic [2:0] {
        S_CLEAR, S_READY, S_ISSUE, S_RESULT, S_CHECK, S_OVER
    } state_t;

    state_t     state, state_n;
    logic       clear_n, turn_n, illegal_n, busy_n, over_n, next_starter;
    logic [1:0] user_n, winner_n, win_code;
    logic [3:0] move_n, count_n;
    logic [1:0] lines [8];

    function automatic logic [1:0] line3(input logic [1:0] a, input logic [1:0] b,
                                         input logic [1:0] c);
        return (a != 2'd0 && a == b && b == c) ? a : 2'd0;
    endfunction

    always_comb begin
        lines[0] = line3(grid_A1, grid_A2, grid_A3);
        lines[1] = line3(grid_B1, grid_B2, grid_B3);
        lines[2] = line3(grid_C1, grid_C2, grid_C3);
        lines[3] = line3(grid_A1, grid_B1, grid_C1);
        lines[4] = line3(grid_A2, grid_B2, grid_C2);
        lines[5] = line3(grid_A3, grid_B3, grid_C3);
        lines[6] = line3(grid_A1, grid_B2, grid_C3);
        lines[7] = line3(grid_A3, grid_B2, grid_C1);
    end

    always_comb begin
        win_code = 2'd0;
        for (int i = 7; i >= 0; i--) begin
            if (lines[i] != 2'd0) win_code = lines[i];
        end
    end

`ifdef STARTER_ALT_EN
    logic starter;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) starter <= 1'b0;
        else if (new_game) starter <= ~starter;
    end

    assign next_starter = new_game ? ~starter : starter;
`else
    assign next_starter = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        clear_n   = 1'b0;
        move_n    = 4'd0;
        user_n    = 2'd0;
        illegal_n = 1'b0;
        turn_n    = turn;
        winner_n  = winner;
        count_n   = move_count;
        if (new_game) begin
            state_n  = S_CLEAR;
            clear_n  = 1'b1;
            count_n  = 4'd0;
            winner_n = 2'd0;
            turn_n   = next_starter;
        end else begin
            case (state)
                // Out of reset the strobe comes one cycle in; after new_game it is already up.
                S_CLEAR: begin
                    if (clear) begin
                        state_n = S_READY;
                    end else begin
                        clear_n  = 1'b1;
                        count_n  = 4'd0;
                        winner_n = 2'd0;
                        turn_n   = next_starter;
                    end
                end
                S_READY: begin
                    if (req) begin
                        if (sel >= 4'd1 && sel <= 4'd9) begin
                            move_n  = sel;
                            user_n  = turn ? P2_CODE : P1_CODE;
                            state_n = S_ISSUE;
                        end else begin
                            illegal_n = 1'b1;
                        end
                    end
                end
                S_ISSUE:  state_n = S_RESULT;
                S_RESULT: begin
                    if (valid) begin
                        count_n = (move_count < 4'd9) ? move_count + 4'd1 : 4'd9;
                        state_n = S_CHECK;
                    end else begin
                        illegal_n = 1'b1;
                        state_n   = S_READY;
                    end
                end
                S_CHECK: begin
                    if (win_code != 2'd0) begin
                        winner_n = win_code;
                        state_n  = S_OVER;
                    end else if (move_count == 4'd9) begin
                        winner_n = 2'd3;
                        state_n  = S_OVER;
                    end else begin
                        turn_n  = ~turn;
                        state_n = S_READY;
                    end
                end
                S_OVER:  state_n = S_OVER;
                default: state_n = S_CLEAR;
            endcase
        end
        busy_n = !(state_n == S_READY || state_n == S_OVER);
        over_n = (state_n == S_OVER);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_CLEAR;
            clear      <= 1'b0;
            move       <= 4'd0;
            user       <= 2'd0;
            turn       <= 1'b0;
            illegal    <= 1'b0;
            winner     <= 2'd0;
            game_over  <= 1'b0;
            move_count <= 4'd0;
            busy       <= 1'b1;
        end else begin
            state      <= state_n;
            clear      <= clear_n;
            move       <= move_n;
            user       <= user_n;
            turn       <= turn_n;
            illegal    <= illegal_n;
            winner     <= winner_n;
            game_over  <= over_n;
            move_count <= count_n;
            busy       <= busy_n;
        end
    end

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller with a behavioural board-storage block.
module tb_turn_controller;
    logic       clk = 1'b0;
    logic       rst, req, new_game, valid;
    logic [3:0] sel;
    logic [1:0] board [9];
    logic       clear, turn, illegal, game_over, busy;
    logic [1:0] user, winner;
    logic [3:0] move, move_count;

    int errors = 0;
    int checks = 0;

    turn_controller dut (
        .clk(clk), .rst(rst), .req(req), .sel(sel), .new_game(new_game), .valid(valid),
        .grid_A1(board[0]), .grid_A2(board[1]), .grid_A3(board[2]),
        .grid_B1(board[3]), .grid_B2(board[4]), .grid_B3(board[5]),
        .grid_C1(board[6]), .grid_C2(board[7]), .grid_C3(board[8]),
        .clear(clear), .user(user), .move(move), .turn(turn), .illegal(illegal),
        .winner(winner), .game_over(game_over), .move_count(move_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // Board storage: writes only empty squares, reports the outcome on valid.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 9; i++) board[i] <= 2'd0;
            valid <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < 9; i++) board[i] <= 2'd0;
        end else if (move >= 4'd1 && move <= 4'd9) begin
            if (board[move - 4'd1] == 2'd0) begin
                board[move - 4'd1] <= user;
                valid <= 1'b1;
            end else begin
                valid <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        bit         ng;
        logic [3:0] s;
        int         et, ec, ew, eo, ei, em;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(bit ng, int s, int et, int ec, int ew, int eo, int ei, int em);
        vec_t v;
        v.ng = ng; v.s = 4'(s); v.et = et; v.ec = ec; v.ew = ew; v.eo = eo; v.ei = ei; v.em = em;
        return v;
    endfunction

    task automatic apply(input vec_t v, input int idx);
        int ill = 0;
        int mv = 0;
        if (v.ng) new_game = 1'b1;
        else begin
            req = 1'b1;
            sel = v.s;
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                req = 1'b0; new_game = 1'b0; sel = 4'd0;
            end
            ill += int'(illegal);
            if (move != 4'd0) mv++;
        end
        chk($sformatf("v%0d turn", idx), 32'(turn), 32'(v.et));
        chk($sformatf("v%0d move_count", idx), 32'(move_count), 32'(v.ec));
        chk($sformatf("v%0d winner", idx), 32'(winner), 32'(v.ew));
        chk($sformatf("v%0d game_over", idx), 32'(game_over), 32'(v.eo));
        chk($sformatf("v%0d illegal_pulses", idx), 32'(ill), 32'(v.ei));
        chk($sformatf("v%0d move_pulses", idx), 32'(mv), 32'(v.em));
    endtask

    initial begin
        // ng, sel, turn, count, winner, over, illegal pulses, move pulses
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 1, 1, 0, 0, 0, 1));
        vt.push_back(mk(0, 1, 1, 1, 0, 0, 1, 1));
        vt.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0));
        vt.push_back(mk(0, 12, 1, 1, 0, 0, 1, 0));
        vt.push_back(mk(0, 4, 0, 2, 0, 0, 0, 1));
        vt.push_back(mk(0, 2, 1, 3, 0, 0, 0, 1));
        vt.push_back(mk(0, 5, 0, 4, 0, 0, 0, 1));
        vt.push_back(mk(0, 3, 0, 5, 1, 1, 0, 1));
        vt.push_back(mk(0, 9, 0, 5, 1, 1, 0, 0));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 1, 1, 0, 0, 0, 1));
        vt.push_back(mk(0, 2, 0, 2, 0, 0, 0, 1));
        vt.push_back(mk(0, 3, 1, 3, 0, 0, 0, 1));
        vt.push_back(mk(0, 5, 0, 4, 0, 0, 0, 1));
        vt.push_back(mk(0, 4, 1, 5, 0, 0, 0, 1));
        vt.push_back(mk(0, 6, 0, 6, 0, 0, 0, 1));
        vt.push_back(mk(0, 8, 1, 7, 0, 0, 0, 1));
        vt.push_back(mk(0, 7, 0, 8, 0, 0, 0, 1));
        vt.push_back(mk(0, 9, 0, 9, 3, 1, 0, 1));
        vt.push_back(mk(0, 5, 0, 9, 3, 1, 0, 0));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 1, 1, 0, 0, 0, 1));
        vt.push_back(mk(0, 4, 0, 2, 0, 0, 0, 1));
        vt.push_back(mk(0, 9, 1, 3, 0, 0, 0, 1));
        vt.push_back(mk(0, 5, 0, 4, 0, 0, 0, 1));
        vt.push_back(mk(0, 3, 1, 5, 0, 0, 0, 1));
        vt.push_back(mk(0, 6, 1, 6, 2, 1, 0, 1));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 1, 1, 0, 0, 0, 1));
        vt.push_back(mk(0, 2, 0, 2, 0, 0, 0, 1));
        vt.push_back(mk(0, 5, 1, 3, 0, 0, 0, 1));
        vt.push_back(mk(0, 3, 0, 4, 0, 0, 0, 1));
        vt.push_back(mk(0, 9, 0, 5, 1, 1, 0, 1));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));

        rst = 1'b0; req = 1'b0; new_game = 1'b0; sel = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst clear", 32'(clear), 32'd0);
        chk("rst busy", 32'(busy), 32'd1);
        chk("rst move", 32'(move), 32'd0);
        chk("rst user", 32'(user), 32'd0);
        chk("rst turn", 32'(turn), 32'd0);
        chk("rst illegal", 32'(illegal), 32'd0);
        chk("rst winner", 32'(winner), 32'd0);
        chk("rst game_over", 32'(game_over), 32'd0);
        chk("rst move_count", 32'(move_count), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("boot clear high", 32'(clear), 32'd1);
        chk("boot busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("boot clear low", 32'(clear), 32'd0);
        chk("boot ready", 32'(busy), 32'd0);

        // First move timing: one-cycle move/user, count in CHECK, turn on return to READY.
        req = 1'b1; sel = 4'd5;
        @(negedge clk);
        req = 1'b0; sel = 4'd0;
        chk("issue move", 32'(move), 32'd5);
        chk("issue user", 32'(user), 32'd1);
        chk("issue busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("result move", 32'(move), 32'd0);
        chk("result user", 32'(user), 32'd0);
        @(negedge clk);
        chk("check count", 32'(move_count), 32'd1);
        chk("check turn", 32'(turn), 32'd0);
        @(negedge clk);
        chk("ready turn", 32'(turn), 32'd1);
        chk("ready busy", 32'(busy), 32'd0);
        chk("ready illegal", 32'(illegal), 32'd0);

        for (int i = 0; i < vt.size(); i++) apply(vt[i], i);

        // new_game during ISSUE aborts the move.
        req = 1'b1; sel = 4'd5;
        @(negedge clk);
        req = 1'b0; sel = 4'd0; new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        chk("abort clear", 32'(clear), 32'd1);
        chk("abort move", 32'(move), 32'd0);
        chk("abort busy", 32'(busy), 32'd1);
        chk("abort count", 32'(move_count), 32'd0);
        @(negedge clk);
        chk("abort ready", 32'(busy), 32'd0);
        chk("abort count2", 32'(move_count), 32'd0);
        apply(mk(0, 5, 1, 1, 0, 0, 0, 1), 100);

        // Async reset during RESULT.
        req = 1'b1; sel = 4'd6;
        @(negedge clk);
        req = 1'b0; sel = 4'd0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst mid count", 32'(move_count), 32'd0);
        chk("rst mid move", 32'(move), 32'd0);
        chk("rst mid busy", 32'(busy), 32'd1);
        chk("rst mid turn", 32'(turn), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reboot clear", 32'(clear), 32'd1);
        @(negedge clk);
        chk("reboot ready", 32'(busy), 32'd0);
        chk("reboot count", 32'(move_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
